stim_misr_harness: RTL

STIM_MISR_HARNESS -- requirements
Module: stim_misr_harness

---
 rtl/stim_misr_harness.sv | 111 +++++++++++
 1 files changed

// File: rtl/stim_misr_harness.sv
// Self-test harness: an LFSR drives stimulus to a DUT and a MISR compacts the DUT
// responses. The valid pipeline lines the responses up with the vectors issued LAT cycles earlier.
module stim_misr_harness #(
    parameter int              IN_W    = 64,
    parameter int              OUT_W   = 32,
    parameter int              NUM_VEC = 20,
    parameter int              LAT     = 0,
    parameter logic [IN_W-1:0]  POLY   = IN_W'(64'h000000000000001B),
    parameter logic [OUT_W-1:0] MPOLY  = OUT_W'(32'h04C11DB7)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IN_W-1:0]  seed,
    input  logic [OUT_W-1:0] expected,
    input  logic [OUT_W-1:0] resp,
    output logic [IN_W-1:0]  stim,
    output logic             stim_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [7:0]       vec_cnt
);
    localparam int CW = (NUM_VEC < 2) ? 1 : $clog2(NUM_VEC + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  issued, comps;
    logic [LAT:0]   vld_pipe;
    logic           accept, kill, last_vec, comp_en, last_comp;
    logic [IN_W-1:0]  lfsr_nxt;
    logic [OUT_W-1:0] misr_nxt;

    assign stim_valid = (state == RUN);
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);
    assign pass       = done && (signature == expected);

    assign lfsr_nxt = {stim[IN_W-2:0], 1'b0} ^ (stim[IN_W-1] ? POLY : '0);
    assign misr_nxt = {signature[OUT_W-2:0], 1'b0} ^ (signature[OUT_W-1] ? MPOLY : '0) ^ resp;

    // vld_pipe[0] is stim_valid itself; vld_pipe[LAT] gates compaction.
    if (LAT > 0) begin : g_pipe
        logic [LAT-1:0] vld_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    vld_q <= '0;
            else if (kill) vld_q <= '0;
            else           vld_q <= vld_pipe[LAT-1:0];
        end
        assign vld_pipe = {vld_q, stim_valid};
    end else begin : g_nopipe
        assign vld_pipe = stim_valid;
    end

    always_comb begin
        accept    = start && !abort && ((state == IDLE) || (state == DONE));
        kill      = abort && busy;
        last_vec  = (state == RUN) && (issued == CW'(NUM_VEC - 1));
        comp_en   = vld_pipe[LAT] && !kill;
        last_comp = comp_en && (comps == CW'(NUM_VEC - 1));
        state_d   = state;
        case (state)
            IDLE, DONE: if (accept) state_d = RUN;
            RUN: begin
                if (abort)         state_d = IDLE;
                else if (last_vec) state_d = (LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (abort)          state_d = IDLE;
                else if (last_comp) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stim      <= '0;
            signature <= '0;
            vec_cnt   <= '0;
            issued    <= '0;
            comps     <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                stim      <= (seed == '0) ? IN_W'(1) : seed;
                signature <= '0;
                vec_cnt   <= '0;
                issued    <= '0;
                comps     <= '0;
            end else begin
                if ((state == RUN) && !abort) begin
                    if (vec_cnt != 8'hFF) vec_cnt <= vec_cnt + 8'd1;
                    // the final vector stays on stim through DRAIN/DONE
                    if (!last_vec) begin
                        stim   <= lfsr_nxt;
                        issued <= issued + CW'(1);
                    end
                end
                if (comp_en) begin
                    signature <= misr_nxt;
                    comps     <= comps + CW'(1);
                end
            end
        end
    end
endmodule
